// File: rtl/vga_pkg.sv
// Shared definitions for the rectangle-fill drawing engine.
// Holds the per-resolution geometry (screen size, coordinate and address
// widths), the colour-width rule and the FSM state encoding. Resolution
// and monochrome selections are passed as fixed-width string literals
// ("320x240"/"160x120", "TRUE"/"FALSE").
package vga_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic bit is_low_res(input logic [55:0] res);
        return res == "160x120";
    endfunction

    function automatic int res_sw(input logic [55:0] res);
        return is_low_res(res) ? 160 : 320;
    endfunction

    function automatic int res_sh(input logic [55:0] res);
        return is_low_res(res) ? 120 : 240;
    endfunction

    function automatic int res_xw(input logic [55:0] res);
        return is_low_res(res) ? 8 : 9;
    endfunction

    function automatic int res_yw(input logic [55:0] res);
        return is_low_res(res) ? 7 : 8;
    endfunction

    function automatic int res_aw(input logic [55:0] res);
        return is_low_res(res) ? 15 : 17;
    endfunction

    function automatic int colour_w(input logic [39:0] mono, input int depth);
        return (mono == 40'("TRUE")) ? 1 : 3 * depth;
    endfunction

endpackage

// File: rtl/vga_rect_clip.sv
// Combinational clipper for a rectangle-fill command.
// Inputs : cmd_x_i, cmd_y_i (top-left), cmd_w_i, cmd_h_i (size in dots).
// Outputs: x_end_o, y_end_o (inclusive clipped right/bottom edge),
//          degen_o (nothing to draw), row_base_o (cmd_y_i * SW).
module vga_rect_clip
    import vga_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int AW = 17,
    parameter int SW = 320,
    parameter int SH = 240
) (
    input  logic [XW-1:0] cmd_x_i,
    input  logic [YW-1:0] cmd_y_i,
    input  logic [XW-1:0] cmd_w_i,
    input  logic [YW-1:0] cmd_h_i,
    output logic [XW-1:0] x_end_o,
    output logic [YW-1:0] y_end_o,
    output logic          degen_o,
    output logic [AW-1:0] row_base_o
);

    localparam logic [XW:0] XMAX = (XW+1)'(SW - 1);
    localparam logic [YW:0] YMAX = (YW+1)'(SH - 1);

    // One extra bit so x+w-1 cannot wrap before the clamp.
    logic [XW:0] x_last;
    logic [YW:0] y_last;

    assign x_last = {1'b0, cmd_x_i} + {1'b0, cmd_w_i} - (XW+1)'(1);
    assign y_last = {1'b0, cmd_y_i} + {1'b0, cmd_h_i} - (YW+1)'(1);

    assign x_end_o = (x_last > XMAX) ? XMAX[XW-1:0] : x_last[XW-1:0];
    assign y_end_o = (y_last > YMAX) ? YMAX[YW-1:0] : y_last[YW-1:0];

    assign degen_o = (cmd_w_i == '0) || (cmd_h_i == '0) ||
                     ({1'b0, cmd_x_i} > XMAX) || ({1'b0, cmd_y_i} > YMAX);

    // Only multiply in the design; the fill loop steps row_base by SW.
    assign row_base_o = AW'(cmd_y_i) * AW'(SW);

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle-fill drawing engine feeding the video-memory write port.
// Accepts (x, y, w, h, colour) over valid/ready, clips to the screen and
// writes one pixel per cycle in raster order, address = y*SW + x.
// Ports: vga_clock, resetn (async, active low); cmd_valid/cmd_ready and
//        cmd_x/y/w/h/colour command bus; busy (filling), done (one-cycle
//        completion pulse); wr_en/wr_address/wr_colour memory write port.
module vga_rect_filler
    import vga_pkg::*;
#(
    parameter logic [55:0] RESOLUTION           = "320x240",
    parameter int          COLOUR_CHANNEL_DEPTH = 1,
    parameter logic [39:0] MONOCHROME           = "FALSE",
    localparam int SW = res_sw(RESOLUTION),
    localparam int SH = res_sh(RESOLUTION),
    localparam int XW = res_xw(RESOLUTION),
    localparam int YW = res_yw(RESOLUTION),
    localparam int AW = res_aw(RESOLUTION),
    localparam int CW = colour_w(MONOCHROME, COLOUR_CHANNEL_DEPTH)
) (
    input  logic          vga_clock,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    input  logic [XW-1:0] cmd_w,
    input  logic [YW-1:0] cmd_h,
    input  logic [CW-1:0] cmd_colour,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [AW-1:0] wr_address,
    output logic [CW-1:0] wr_colour
);

    logic [1:0]    state_q, state_d;
    logic [XW-1:0] cur_x_q, cur_x_d, x_start_q, x_start_d, x_end_q, x_end_d;
    logic [YW-1:0] cur_y_q, cur_y_d, y_end_q, y_end_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_address_q, wr_address_d;
    logic [CW-1:0] wr_colour_q, wr_colour_d;

    logic [XW-1:0] clip_x_end;
    logic [YW-1:0] clip_y_end;
    logic          clip_degen;
    logic [AW-1:0] clip_row_base;

    vga_rect_clip #(
        .XW(XW), .YW(YW), .AW(AW), .SW(SW), .SH(SH)
    ) u_clip (
        .cmd_x_i    (cmd_x),
        .cmd_y_i    (cmd_y),
        .cmd_w_i    (cmd_w),
        .cmd_h_i    (cmd_h),
        .x_end_o    (clip_x_end),
        .y_end_o    (clip_y_end),
        .degen_o    (clip_degen),
        .row_base_o (clip_row_base)
    );

    // The write-port registers are loaded with the *next* pixel so that the
    // first write appears in the very first FILL cycle. wr_colour_q doubles
    // as the latched fill colour.
    always_comb begin
        state_d      = state_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        x_start_d    = x_start_q;
        x_end_d      = x_end_q;
        y_end_d      = y_end_q;
        row_base_d   = row_base_q;
        wr_en_d      = 1'b0;
        wr_address_d = wr_address_q;
        wr_colour_d  = wr_colour_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    x_start_d  = cmd_x;
                    x_end_d    = clip_x_end;
                    y_end_d    = clip_y_end;
                    cur_x_d    = cmd_x;
                    cur_y_d    = cmd_y;
                    row_base_d = clip_row_base;
                    if (clip_degen) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_FILL;
                        wr_en_d      = 1'b1;
                        wr_address_d = clip_row_base + AW'(cmd_x);
                        wr_colour_d  = cmd_colour;
                    end
                end
            end
            S_FILL: begin
                if (cur_x_q < x_end_q) begin
                    cur_x_d      = cur_x_q + XW'(1);
                    wr_en_d      = 1'b1;
                    wr_address_d = row_base_q + AW'(cur_x_d);
                end else if (cur_y_q < y_end_q) begin
                    cur_x_d      = x_start_q;
                    cur_y_d      = cur_y_q + YW'(1);
                    row_base_d   = row_base_q + AW'(SW);
                    wr_en_d      = 1'b1;
                    wr_address_d = row_base_d + AW'(x_start_q);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            x_start_q    <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
            row_base_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
            wr_colour_q  <= '0;
        end else begin
            state_q      <= state_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            x_start_q    <= x_start_d;
            x_end_q      <= x_end_d;
            y_end_q      <= y_end_d;
            row_base_q   <= row_base_d;
            wr_en_q      <= wr_en_d;
            wr_address_q <= wr_address_d;
            wr_colour_q  <= wr_colour_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q == S_FILL);
    assign done       = (state_q == S_DONE);
    assign wr_en      = wr_en_q;
    assign wr_address = wr_address_q;
    assign wr_colour  = wr_colour_q;

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for vga_rect_filler: a 320x240 instance and a 160x120
// instance share one clock. Expected writes are queued when a command is
// driven and popped as the DUT writes.
module tb_vga_rect_filler;

    localparam int SW = 320;
    localparam int SH = 240;

    logic vga_clock = 1'b0;
    logic resetn    = 1'b0;
    always #5 vga_clock = ~vga_clock;

    // 320x240 instance
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [8:0]  cmd_w = '0;
    logic [7:0]  cmd_h = '0;
    logic [2:0]  cmd_colour = '0;
    logic        busy, done, wr_en;
    logic [16:0] wr_address;
    logic [2:0]  wr_colour;

    // 160x120 instance
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [7:0]  b_x = '0;
    logic [6:0]  b_y = '0;
    logic [7:0]  b_w = '0;
    logic [6:0]  b_h = '0;
    logic [2:0]  b_colour = '0;
    logic        b_busy, b_done, b_wr_en;
    logic [14:0] b_wr_address;
    logic [2:0]  b_wr_colour;

    vga_rect_filler dut_a (
        .vga_clock(vga_clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_colour(cmd_colour), .busy(busy), .done(done),
        .wr_en(wr_en), .wr_address(wr_address), .wr_colour(wr_colour)
    );

    vga_rect_filler #(.RESOLUTION("160x120")) dut_b (
        .vga_clock(vga_clock), .resetn(resetn),
        .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_x(b_x), .cmd_y(b_y), .cmd_w(b_w), .cmd_h(b_h),
        .cmd_colour(b_colour), .busy(b_busy), .done(b_done),
        .wr_en(b_wr_en), .wr_address(b_wr_address), .wr_colour(b_wr_colour)
    );

    int n_cmp = 0;
    int n_err = 0;
    int qa[$];   // expected writes, packed as address*8 + colour
    int qb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, score any writes.
    task automatic tick();
        int e;
        @(posedge vga_clock);
        #1;
        if (wr_en !== 1'b0) begin
            if (qa.size() == 0) chk("unexpected_write_a", wr_address, 32'hFFFF_FFFF);
            else begin
                e = qa.pop_front();
                chk("wr_address_a", wr_address, e / 8);
                chk("wr_colour_a", wr_colour, e % 8);
            end
        end
        if (b_wr_en !== 1'b0) begin
            if (qb.size() == 0) chk("unexpected_write_b", b_wr_address, 32'hFFFF_FFFF);
            else begin
                e = qb.pop_front();
                chk("wr_address_b", b_wr_address, e / 8);
                chk("wr_colour_b", b_wr_colour, e % 8);
            end
        end
    endtask

    // Reference model: push the clipped raster-order writes, return count.
    task automatic model_push(input int x, input int y, input int w, input int h,
                              input int col, output int n);
        int xe, ye;
        n = 0;
        if (w != 0 && h != 0 && x < SW && y < SH) begin
            xe = (x + w - 1 > SW - 1) ? SW - 1 : x + w - 1;
            ye = (y + h - 1 > SH - 1) ? SH - 1 : y + h - 1;
            for (int yy = y; yy <= ye; yy++)
                for (int xx = x; xx <= xe; xx++) begin
                    qa.push_back((yy * SW + xx) * 8 + col);
                    n++;
                end
        end
    endtask

    // Present a command for one accept cycle, then scramble the inputs.
    task automatic send(input int x, input int y, input int w, input int h,
                        input int col, output int n);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 1);
        cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h);
        cmd_colour = 3'(col);
        cmd_valid = 1'b1;
        model_push(x, y, w, h, col, n);
        tick();
        cmd_valid = 1'b0;
        cmd_x = 9'($urandom); cmd_y = 8'($urandom);
        cmd_w = 9'($urandom); cmd_h = 8'($urandom);
        cmd_colour = 3'($urandom);
    endtask

    // Called right after the accept tick (cycle T+1).
    task automatic finish_cmd(input int n);
        int k;
        k = 1;
        while (done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("done_latency", k, n + 1);
        chk("queue_drained", qa.size(), 0);
        chk("wr_en_in_done", {31'd0, wr_en}, 0);
        chk("ready_in_done", {31'd0, cmd_ready}, 0);
        tick();
        chk("ready_after_done", {31'd0, cmd_ready}, 1);
        chk("done_one_cycle", {31'd0, done}, 0);
    endtask

    initial begin
        int n;
        #12;
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_wr_address", {15'd0, wr_address}, 0);
        chk("rst_wr_colour", {29'd0, wr_colour}, 0);
        chk("rst_b_ready", {31'd0, b_ready}, 1);
        chk("rst_b_wr_en", {31'd0, b_wr_en}, 0);
        resetn = 1'b1;
        tick();

        // Basic 3x2 fill: 1610..1612, 1930..1932
        send(10, 5, 3, 2, 3'b101, n);
        chk("busy_in_fill", {31'd0, busy}, 1);
        finish_cmd(n);
        chk("address_holds", {15'd0, wr_address}, 1932);
        chk("colour_holds", {29'd0, wr_colour}, 5);

        // Right/bottom clipping: 76798, 76799
        send(318, 239, 5, 4, 3'b011, n);
        chk("clip_count", n, 2);
        finish_cmd(n);

        // Degenerate commands
        send(10, 10, 0, 5, 3'b111, n);
        finish_cmd(n);
        send(320, 0, 1, 1, 3'b111, n);
        finish_cmd(n);
        send(5, 240, 2, 2, 3'b001, n);
        finish_cmd(n);
        send(7, 7, 4, 0, 3'b001, n);
        finish_cmd(n);

        // Back-pressure: valid held, cmd_x wanders during a 1x3 fill
        chk("bp_ready", {31'd0, cmd_ready}, 1);
        cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd1; cmd_h = 8'd3; cmd_colour = 3'd6;
        cmd_valid = 1'b1;
        model_push(0, 0, 1, 3, 6, n);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_ready_low", {31'd0, cmd_ready}, 0);
            cmd_x = 9'($urandom_range(0, 319));
            tick();
        end
        chk("bp_ready_back", {31'd0, cmd_ready}, 1);
        chk("bp_first_drained", qa.size(), 0);
        cmd_x = 9'd5; cmd_y = 8'd0; cmd_w = 9'd1; cmd_h = 8'd1; cmd_colour = 3'd2;
        model_push(5, 0, 1, 1, 2, n);
        tick();
        cmd_valid = 1'b0;
        finish_cmd(n);

        // Reset during the 4th write of a 4x4 fill
        send(2, 3, 4, 4, 3'b111, n);
        tick();
        tick();
        tick();
        chk("rst_mid_writes_left", qa.size(), 12);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, wr_en}, 0);
        chk("midrst_wr_address", {15'd0, wr_address}, 0);
        chk("midrst_wr_colour", {29'd0, wr_colour}, 0);
        chk("midrst_ready", {31'd0, cmd_ready}, 1);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        qa.delete();
        tick();
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_idle", {31'd0, cmd_ready}, 1);
        send(100, 200, 2, 1, 3'b001, n);
        finish_cmd(n);

        // 160x120 corner pixel
        chk("b_ready_before", {31'd0, b_ready}, 1);
        b_x = 8'd159; b_y = 7'd119; b_w = 8'd1; b_h = 7'd1; b_colour = 3'd4;
        b_valid = 1'b1;
        qb.push_back(19199 * 8 + 4);
        tick();
        b_valid = 1'b0;
        chk("b_queue_drained", qb.size(), 0);
        tick();
        chk("b_done", {31'd0, b_done}, 1);
        chk("b_address_holds", {17'd0, b_wr_address}, 19199);
        tick();
        chk("b_ready_after", {31'd0, b_ready}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_rect_filler.md
Name: vga_rect_filler

Overview:
- Drawing engine on vga_clock, one stage upstream of video memory.
- Accepts rectangle-fill commands (x, y, w, h, colour) over a valid/ready handshake.
- Clips each rectangle to the screen, then writes one pixel per cycle in raster order into the video-memory write port.
- The VGA controller scans that memory for display.

Parameters:
- RESOLUTION, "320x240", "320x240" or "160x120"; sets the coordinate and address widths.
- COLOUR_CHANNEL_DEPTH, 1, bits per R/G/B channel.
- MONOCHROME, "FALSE", "TRUE" makes the colour width 1.

Ports:
- vga_clock  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle; command accepted when cmd_valid & cmd_ready.
- cmd_x  in  XW  left column; XW=9 (320x240) or 8 (160x120).
- cmd_y  in  YW  top row; YW=8 or 7.
- cmd_w  in  XW  width in dots.
- cmd_h  in  YW  height in dots.
- cmd_colour  in  CW  fill colour; CW = MONOCHROME ? 1 : 3*COLOUR_CHANNEL_DEPTH.
- busy  out  1  fill in progress (state FILL).
- done  out  1  one-cycle pulse when a command completes.
- wr_en  out  1  video-memory write strobe.
- wr_address  out  AW  write address; AW=17 or 15.
- wr_colour  out  CW  write data.

Behaviour:
- Constants:
  - SW = 320 or 160; SH = 240 or 120.
  - Address = y*SW + x, the same mapping the controller reads with.
- Reset (asynchronous, any state including mid-fill):
  - state IDLE; cmd_ready=1; busy=0; done=0; wr_en=0; wr_address=0; wr_colour=0.
  - An in-progress fill is abandoned and no further writes are issued.
- States:
  - IDLE: cmd_ready=1. On accept at cycle T:
    - latch colour;
    - compute clipped bounds x_end = min(x+w-1, SW-1) and y_end = min(y+h-1, SH-1), using XW+1 / YW+1 bit sums so they never wrap;
    - load cur_x=x, cur_y=y, row_base=y*SW.
    - Degenerate command (w==0, h==0, x>=SW or y>=SH) -> go to DONE. Otherwise -> go to FILL.
  - FILL (entered at T+1): registered outputs each cycle are wr_en=1, wr_address=row_base+cur_x, wr_colour=latched colour.
    - If cur_x<x_end: cur_x++.
    - Else if cur_y<y_end: cur_x=x, cur_y++, row_base+=SW (no multiplier in the loop).
    - Else: -> DONE.
  - DONE: one cycle; done=1, wr_en=0 -> IDLE.
- Timing:
  - First write at T+1; last write at T+N, where N is the clipped pixel count.
  - done at T+N+1; cmd_ready high again at T+N+2.
  - Degenerate command: done at T+1, zero writes.
- Handshake and output rules:
  - cmd_ready=0 in FILL and DONE; cmd_valid is ignored there.
  - Command inputs are sampled only on the accept cycle; later changes to them have no effect.
  - wr_en=0 in every state except FILL.
  - wr_address and wr_colour hold their last values when wr_en=0.
- Width rules:
  - All address arithmetic is in AW bits.
  - The maximum address (SW*SH-1 = 76799 or 19199) fits without overflow.

Decomposition:
- Shared package vga_pkg holds:
  - per-resolution constants SW, SH, XW, YW, AW;
  - colour-width function CW;
  - state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2).
- One sub-module: vga_rect_clip (combinational). It takes cmd_x, cmd_y, cmd_w, cmd_h and produces x_end, y_end, degenerate flag and start row_base.
- The FSM, counters and write-port registers stay in vga_rect_filler.

Test Plan:
- Basic fill (320x240): accept x=10, y=5, w=3, h=2, colour=3'b101 at T.
  - Writes at T+1..T+6 to addresses 1610, 1611, 1612, 1930, 1931, 1932, colour 101.
  - done at T+7; cmd_ready at T+8.
- Right/bottom clipping: x=318, y=239, w=5, h=4.
  - Exactly 2 writes, addresses 76798 and 76799; done at T+3.
- Degenerate commands: w=0; then x=320 (w=1, h=1).
  - Each gives zero wr_en, done at T+1, cmd_ready at T+2.
- Back-pressure: hold cmd_valid=1 with changing cmd_x during a 1x3 fill at x=0, y=0.
  - Writes go to addresses 0, 320, 640 only.
  - The second command is accepted only when cmd_ready returns.
- Reset mid-fill: assert resetn=0 during the 4th write of a 4x4 fill.
  - All outputs go to their reset values immediately; no writes after release.
  - The next command fills correctly.
- 160x120 build: x=159, y=119, w=1, h=1.
  - One write at address 19199 on a 15-bit bus.
